dmem_bytelane: RTL

- Parametrised successor to the CPU's single-port data memory, sized for RV32 loads and stores.
- Word-organised synchronous RAM addressed by byte.
- Stores: byte-lane write enables for SB/SH/SW.
- Loads: LB/LH/LW/LBU/LHU, with lane extraction and sign/zero extension in the registered read stage.
- Sits between the CPU MEM stage and its writeback mux; one-cycle load latency, with a valid strobe and a misalignment flag.

---
 rtl/dmem_bytelane.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed, word-organised synchronous data RAM for RV32
// loads and stores. Byte-lane writes for SB/SH/SW. Lane extraction and
// sign/zero extension for LB/LH/LW/LBU/LHU happen in the registered read stage.
//
// Handshake: re/we are single-cycle requests with no backpressure, so every
// request is accepted in the cycle it is presented. rvalid and misaligned
// answer exactly one cycle later, and rdata is meaningful when rvalid=1.
//
// Optional macro DMEM_RDW_FWD_EN selects the read-during-write policy:
//   defined   = write-first: registered write data and lane mask are merged
//               into the read stage.
//   undefined = read-first: plain block-RAM template with no bypass.
module dmem_bytelane #(
  parameter int    DEPTH_WORDS = 32768,
  parameter int    ADDR_W      = $clog2(DEPTH_WORDS) + 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misaligned
);

  localparam int IDX_W = ADDR_W - 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             mis;
  logic             wr_en;
  logic             rd_en;
  logic [3:0]       wmask;
  logic [31:0]      wlanes;

  assign idx  = addr[ADDR_W-1:2];
  assign lane = addr[1:0];

  // Decode alignment. Size 11 behaves exactly like size 10 (word).
  always_comb begin
    mis = 1'b0;
    if (size[1])            mis = (lane != 2'b00);
    else if (size == 2'b01) mis = lane[0];
  end

  // A request sampled during reset or at a misaligned address touches nothing.
  assign wr_en = rst_n && we && !mis;
  assign rd_en = rst_n && re && !mis;

  // Build the lane mask and replicate store data across the lanes it may land on.
  always_comb begin
    wmask  = 4'b0000;
    wlanes = wdata;
    if (size[1]) begin
      wmask  = 4'b1111;
      wlanes = wdata;
    end else if (size == 2'b01) begin
      wmask  = lane[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata[15:0]}};
    end else begin
      wmask  = 4'b0001 << lane;
      wlanes = {4{wdata[7:0]}};
    end
  end

  logic [31:0] ram_q;

  // RAM port: byte-lane write, and a read-first registered read of the same word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wmask[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
    end
    if (rd_en) ram_q <= mem[idx];
  end

  logic        load_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [31:0] hold_q;

  // Response stage: load bookkeeping, status strobes and the held rdata value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
      hold_q     <= 32'h0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      load_q     <= re && !mis;
      rvalid     <= re;
      misaligned <= (re || we) && mis;
      hold_q     <= rdata;
      if (rd_en) begin
        size_q <= size;
        lane_q <= lane;
        uns_q  <= ld_unsigned;
      end
    end
  end

  logic [31:0] word_sel;

`ifdef DMEM_RDW_FWD_EN
  logic [3:0]  fwd_mask_q;
  logic [31:0] fwd_data_q;

  // Capture what a same-cycle store wrote so the load can see the new bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      fwd_mask_q <= (rd_en && wr_en) ? wmask : 4'b0000;
      fwd_data_q <= wlanes;
    end
  end

  // Merge forwarded lanes over the pre-write RAM word.
  always_comb begin
    word_sel = ram_q;
    for (int b = 0; b < 4; b++) begin
      if (fwd_mask_q[b]) word_sel[8*b +: 8] = fwd_data_q[8*b +: 8];
    end
  end
`else
  // Read-first: the registered RAM word is the answer.
  always_comb begin
    word_sel = ram_q;
  end
`endif

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  // Extract the lane from the registered word and sign/zero-extend it.
  always_comb begin
    byte_v = word_sel[8*lane_q +: 8];
    half_v = lane_q[1] ? word_sel[31:16] : word_sel[15:0];
    if (size_q[1])            ext_v = word_sel;
    else if (size_q == 2'b01) ext_v = {{16{!uns_q && half_v[15]}}, half_v};
    else                      ext_v = {{24{!uns_q && byte_v[7]}}, byte_v};
  end

  // Output mux: fresh load result, zero for a misaligned load, otherwise hold.
  always_comb begin
    if (load_q)      rdata = ext_v;
    else if (rvalid) rdata = 32'h0;
    else             rdata = hold_q;
  end

endmodule
